// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch/decode/execute slice.
// Contents: instruction codes, ALU function codes, condition function codes,
// special register IDs, the register-file depth and a condition evaluator.
package y86_pkg;

  // Instruction codes (high nibble of byte 0)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes (ifun of OPq)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition function codes (ifun of jXX / cmovXX)
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // Register IDs
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NUM_REGS = 15;

  // Evaluate a jXX/cmovXX condition against a set of condition codes
  function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (fn)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = ~zf;
      C_GE:     cond_eval = ~lt;
      C_G:      cond_eval = ~lt & ~zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_execute_if.sv
// Bus bundle between the fetch/decode/execute core and its environment.
// master: drives PC, the 10-byte instruction window and the data-memory
//         read result valM; observes all decoded/computed outputs.
// slave : the core; consumes PC/instr/valM, drives icode..halt.
interface fetch_decode_execute_if;
  logic [63:0] PC;
  logic [79:0] instr;
  logic [63:0] valM;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valE;
  logic        cnd;
  logic        zf;
  logic        sf;
  logic        of;
  logic        valid_instr;
  logic        ins_mem_error;
  logic        halt;

  modport master (
    output PC, instr, valM,
    input  icode, ifun, rA, rB, valC, valP, valA, valB, valE,
    input  cnd, zf, sf, of, valid_instr, ins_mem_error, halt
  );

  modport slave (
    input  PC, instr, valM,
    output icode, ifun, rA, rB, valC, valP, valA, valB, valE,
    output cnd, zf, sf, of, valid_instr, ins_mem_error, halt
  );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86-64 register file.
// Ports: clk, rst (async, active-high, clears all registers);
//   src_a/src_b -> val_a/val_b : asynchronous read ports, ID F reads 0;
//   dst_e/val_e, dst_m/val_m   : write ports, ID F means no write, and
//                                the M port wins when both name one register.
// With FDE_DBG_PORT_EN defined a third read port src_dbg -> val_dbg exists.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
`ifdef FDE_DBG_PORT_EN
  input  logic [3:0]  src_dbg,
  output logic [63:0] val_dbg,
`endif
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs_r [NUM_REGS];

  // Read ports: scan the array so ID F naturally falls through to zero
  always_comb begin
    val_a = 64'd0;
    val_b = 64'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      val_a = (src_a == 4'(i)) ? regs_r[i] : val_a;
      val_b = (src_b == 4'(i)) ? regs_r[i] : val_b;
    end
  end

`ifdef FDE_DBG_PORT_EN
  // Debug read port, same zero-for-F behaviour as the operand ports
  always_comb begin
    val_dbg = 64'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      val_dbg = (src_dbg == 4'(i)) ? regs_r[i] : val_dbg;
    end
  end
`endif

  // Register state: async clear; M write has priority over E (popq %rsp)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dst_m == 4'(i)) begin
          regs_r[i] <= val_m;
        end else if (dst_e == 4'(i)) begin
          regs_r[i] <= val_e;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_decode_execute.sv
// Single-cycle Y86-64 fetch, decode/writeback and execute stage.
// Ports: clk, rst (async, active-high);
//   bus (slave modport): PC, instr (10 bytes, byte at PC in [79:72]) and
//   valM in; decoded fields, valC/valP/valA/valB/valE, cnd, the current
//   condition codes and the valid_instr/ins_mem_error/halt status out.
// Parameter IMEM_BYTES: instruction memory size; an instruction reaching
//   past it raises ins_mem_error.
// Optional macro FDE_DBG_PORT_EN adds dbg_sel (in) / dbg_data (out), a
//   combinational register read returning 0 for ID F.
module fetch_decode_execute
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 20480
) (
  input logic clk,
  input logic rst,
  fetch_decode_execute_if.slave bus
`ifdef FDE_DBG_PORT_EN
  ,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_data
`endif
);

  logic [3:0]  icode_s, ifun_s, ra_s, rb_s;
  logic [63:0] valc_s;
  logic [3:0]  len_s;
  logic        valid_s, mem_err_s, halt_s;
  logic [64:0] end_addr_s;
  logic [3:0]  src_a_s, src_b_s, dst_e_s, dst_m_s;
  logic [63:0] val_a_s, val_b_s, val_e_s, alu_s;
  logic        alu_of_s, cnd_s, commit_s, cc_load_s;
  logic        zf_r, sf_r, of_r;

  // Fetch: split the window into fields, length, constant and legality
  always_comb begin
    icode_s = bus.instr[79:76];
    ifun_s  = bus.instr[75:72];
    ra_s    = RNONE;
    rb_s    = RNONE;
    valc_s  = 64'd0;
    len_s   = 4'd1;
    valid_s = 1'b0;
    case (icode_s)
      I_HALT, I_NOP, I_RET: begin
        len_s   = 4'd1;
        valid_s = (ifun_s == 4'h0);
      end
      I_CMOV: begin
        len_s   = 4'd2;
        ra_s    = bus.instr[71:68];
        rb_s    = bus.instr[67:64];
        valid_s = (ifun_s <= C_G);
      end
      I_OPQ: begin
        len_s   = 4'd2;
        ra_s    = bus.instr[71:68];
        rb_s    = bus.instr[67:64];
        valid_s = (ifun_s <= ALU_XOR);
      end
      I_PUSHQ, I_POPQ: begin
        len_s   = 4'd2;
        ra_s    = bus.instr[71:68];
        rb_s    = bus.instr[67:64];
        valid_s = (ifun_s == 4'h0);
      end
      I_JXX: begin
        len_s   = 4'd9;
        valc_s  = bus.instr[71:8];
        valid_s = (ifun_s <= C_G);
      end
      I_CALL: begin
        len_s   = 4'd9;
        valc_s  = bus.instr[71:8];
        valid_s = (ifun_s == 4'h0);
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len_s   = 4'd10;
        ra_s    = bus.instr[71:68];
        rb_s    = bus.instr[67:64];
        valc_s  = bus.instr[63:0];
        valid_s = (ifun_s == 4'h0);
      end
      default: begin
        len_s   = 4'd1;
        valid_s = 1'b0;
      end
    endcase
  end

  // One extra bit keeps PC + length from wrapping before the bound check
  assign end_addr_s = {1'b0, bus.PC} + {61'd0, len_s};
  assign mem_err_s  = (end_addr_s > 65'(IMEM_BYTES));
  assign halt_s     = (icode_s == I_HALT);
  assign commit_s   = valid_s & ~mem_err_s & ~halt_s;

  // Decode: operand register selection
  always_comb begin
    src_a_s = RNONE;
    src_b_s = RNONE;
    case (icode_s)
      I_CMOV, I_OPQ, I_PUSHQ: src_a_s = ra_s;
      I_RMMOVQ: begin
        src_a_s = ra_s;
        src_b_s = rb_s;
      end
      I_MRMOVQ: src_b_s = rb_s;
      I_RET, I_POPQ: begin
        src_a_s = RSP;
        src_b_s = RSP;
      end
      I_CALL: src_b_s = RSP;
      default: begin
        src_a_s = RNONE;
        src_b_s = RNONE;
      end
    endcase
    // OPq and pushq read rB / RSP as their second operand
    if (icode_s == I_OPQ) begin
      src_b_s = rb_s;
    end else if (icode_s == I_PUSHQ) begin
      src_b_s = RSP;
    end else begin
      src_b_s = src_b_s;
    end
  end

  y86_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .src_a (src_a_s),
    .src_b (src_b_s),
    .val_a (val_a_s),
    .val_b (val_b_s),
`ifdef FDE_DBG_PORT_EN
    .src_dbg (dbg_sel),
    .val_dbg (dbg_data),
`endif
    .dst_e (dst_e_s),
    .val_e (val_e_s),
    .dst_m (dst_m_s),
    .val_m (bus.valM)
  );

  // ALU for OPq: result and signed-overflow flag
  always_comb begin
    alu_s    = 64'd0;
    alu_of_s = 1'b0;
    case (ifun_s)
      ALU_ADD: begin
        alu_s    = val_b_s + val_a_s;
        alu_of_s = (val_a_s[63] == val_b_s[63]) && (alu_s[63] != val_b_s[63]);
      end
      ALU_SUB: begin
        alu_s    = val_b_s - val_a_s;
        alu_of_s = (val_b_s[63] != val_a_s[63]) && (alu_s[63] != val_b_s[63]);
      end
      ALU_AND: alu_s = val_b_s & val_a_s;
      ALU_XOR: alu_s = val_b_s ^ val_a_s;
      default: begin
        alu_s    = 64'd0;
        alu_of_s = 1'b0;
      end
    endcase
  end

  // Execute: valE per instruction class
  always_comb begin
    val_e_s = 64'd0;
    case (icode_s)
      I_CMOV:             val_e_s = val_a_s;
      I_IRMOVQ:           val_e_s = valc_s;
      I_RMMOVQ, I_MRMOVQ: val_e_s = val_b_s + valc_s;
      I_OPQ:              val_e_s = alu_s;
      I_CALL, I_PUSHQ:    val_e_s = val_b_s - 64'd8;
      I_RET, I_POPQ:      val_e_s = val_b_s + 64'd8;
      default:            val_e_s = 64'd0;
    endcase
  end

  assign cnd_s = ((icode_s == I_JXX) || (icode_s == I_CMOV)) ?
                 cond_eval(ifun_s, zf_r, sf_r, of_r) : 1'b0;

  // Writeback destinations; forced to F whenever the instruction may not commit
  always_comb begin
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    if (commit_s) begin
      case (icode_s)
        I_IRMOVQ, I_OPQ:         dst_e_s = rb_s;
        I_CMOV:                  dst_e_s = cnd_s ? rb_s : RNONE;
        I_CALL, I_RET, I_PUSHQ:  dst_e_s = RSP;
        I_POPQ: begin
          dst_e_s = RSP;
          dst_m_s = ra_s;
        end
        I_MRMOVQ:                dst_m_s = ra_s;
        default: begin
          dst_e_s = RNONE;
          dst_m_s = RNONE;
        end
      endcase
    end else begin
      dst_e_s = RNONE;
      dst_m_s = RNONE;
    end
  end

  assign cc_load_s = commit_s && (icode_s == I_OPQ);

  // Condition-code register: ZF set out of reset, loads only on a committing OPq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_r <= 1'b1;
      sf_r <= 1'b0;
      of_r <= 1'b0;
    end else if (cc_load_s) begin
      zf_r <= (alu_s == 64'd0);
      sf_r <= alu_s[63];
      of_r <= alu_of_s;
    end
  end

  assign bus.icode         = icode_s;
  assign bus.ifun          = ifun_s;
  assign bus.rA            = ra_s;
  assign bus.rB            = rb_s;
  assign bus.valC          = valc_s;
  assign bus.valP          = bus.PC + {60'd0, len_s};
  assign bus.valA          = val_a_s;
  assign bus.valB          = val_b_s;
  assign bus.valE          = val_e_s;
  assign bus.cnd           = cnd_s;
  assign bus.zf            = zf_r;
  assign bus.sf            = sf_r;
  assign bus.of            = of_r;
  assign bus.valid_instr   = valid_s;
  assign bus.ins_mem_error = mem_err_s;
  assign bus.halt          = halt_s;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Scoreboard bench for fetch_decode_execute: a driver issues one instruction
// per cycle and pushes the reference model's expectation; a monitor pops and
// compares on the falling edge.
module tb_fetch_decode_execute;

  localparam int IMEM = 20480;

  logic clk = 1'b0;
  logic rst;
  fetch_decode_execute_if bus ();

`ifdef FDE_DBG_PORT_EN
  logic [3:0]  dbg_sel = 4'h0;
  logic [63:0] dbg_data;
`endif

  fetch_decode_execute #(.IMEM_BYTES(IMEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FDE_DBG_PORT_EN
    ,
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, vala, valb, vale;
    logic        cnd, zf, sf, of, valid, memerr, halt;
    bit          full, check_cnd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Architectural reference state
  logic [63:0] m_regs [15];
  bit m_zf, m_sf, m_of;
  int len_tab [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
  int maxfn_tab [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
  endtask

  function automatic logic [63:0] m_rd(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : m_regs[r];
  endfunction

  function automatic bit holds(input logic [3:0] fn);
    bit lt;
    lt = m_sf ^ m_of;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || m_zf;
      4'd2: return lt;
      4'd3: return m_zf;
      4'd4: return !m_zf;
      4'd5: return !lt;
      4'd6: return !lt && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: expected outputs now, architectural effect of the next edge
  task automatic model_step(input logic [63:0] pc, input logic [79:0] ins,
                            input logic [63:0] vm, output exp_t e);
    logic [7:0] b [10];
    logic [3:0] ic, fn, sa, sb, de, dm;
    logic [63:0] va, vb, res;
    logic signed [64:0] w;
    logic [64:0] endp;
    bit known, ovf;
    int len;
    for (int k = 0; k < 10; k++) b[k] = ins[79-8*k -: 8];
    ic = b[0][7:4];
    fn = b[0][3:0];
    known = (ic < 4'd12);
    len = known ? len_tab[ic] : 1;
    e.icode = ic; e.ifun = fn;
    e.valid = known && (int'(fn) <= maxfn_tab[known ? ic : 4'd0]);
    e.full = known;
    if (known && len >= 2 && ic != 4'h7 && ic != 4'h8) begin
      e.ra = b[1][7:4]; e.rb = b[1][3:0];
    end else begin
      e.ra = 4'hF; e.rb = 4'hF;
    end
    e.valc = 64'd0;
    if (ic == 4'h7 || ic == 4'h8) for (int k = 1; k <= 8; k++) e.valc = {e.valc[55:0], b[k]};
    if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) for (int k = 2; k <= 9; k++) e.valc = {e.valc[55:0], b[k]};
    e.valp = pc + 64'(len);
    endp = {1'b0, pc} + 65'(len);
    e.memerr = (endp > 65'(IMEM));
    e.halt = (ic == 4'h0);
    sa = (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) ? e.ra :
         (ic == 4'h9 || ic == 4'hB) ? 4'h4 : 4'hF;
    sb = (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) ? e.rb :
         (ic >= 4'h8 && ic <= 4'hB) ? 4'h4 : 4'hF;
    va = m_rd(sa); vb = m_rd(sb);
    e.vala = va; e.valb = vb;
    e.check_cnd = e.valid && (ic == 4'h2 || ic == 4'h7);
    e.cnd = holds(fn);
    res = 64'd0; ovf = 1'b0;
    case (fn)
      4'd0: begin w = $signed({vb[63], vb}) + $signed({va[63], va}); res = w[63:0]; ovf = w[64] ^ w[63]; end
      4'd1: begin w = $signed({vb[63], vb}) - $signed({va[63], va}); res = w[63:0]; ovf = w[64] ^ w[63]; end
      4'd2: res = vb & va;
      4'd3: res = vb ^ va;
      default: res = 64'd0;
    endcase
    case (ic)
      4'h2: e.vale = va;
      4'h3: e.vale = e.valc;
      4'h4, 4'h5: e.vale = vb + e.valc;
      4'h6: e.vale = res;
      4'h8, 4'hA: e.vale = vb - 64'd8;
      4'h9, 4'hB: e.vale = vb + 64'd8;
      default: e.vale = 64'd0;
    endcase
    e.zf = m_zf; e.sf = m_sf; e.of = m_of;
    if (e.valid && !e.memerr && !e.halt) begin
      de = (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && e.cnd)) ? e.rb :
           (ic >= 4'h8 && ic <= 4'hB) ? 4'h4 : 4'hF;
      dm = (ic == 4'h5 || ic == 4'hB) ? e.ra : 4'hF;
      if (de != 4'hF) m_regs[de] = e.vale;
      if (dm != 4'hF) m_regs[dm] = vm;
      if (ic == 4'h6) begin
        m_zf = (res == 64'd0); m_sf = res[63]; m_of = ovf;
      end
    end
  endtask

  task automatic issue(input logic [63:0] pc, input logic [79:0] ins, input logic [63:0] vm);
    exp_t e;
    bus.PC = pc; bus.instr = ins; bus.valM = vm;
    model_step(pc, ins, vm, e);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] irm(input logic [3:0] ic, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [63:0] v);
    return {ic, 4'h0, ra, rb, v};
  endfunction

  function automatic logic [79:0] rr(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [3:0] ra, input logic [3:0] rb);
    return {ic, fn, ra, rb, 64'd0};
  endfunction

  function automatic logic [79:0] rand_instr();
    logic [79:0] w;
    logic [3:0] ic, fn;
    w = {$urandom(), $urandom(), 16'($urandom())};
    ic = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
    if ($urandom_range(0, 7) == 0) fn = 4'($urandom_range(0, 15));
    else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
    else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
    else fn = 4'h0;
    w[79:72] = {ic, fn};
    return w;
  endfunction

  // Monitor: compare every presented instruction against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("icode", 64'(bus.icode), 64'(e.icode));
        check("ifun", 64'(bus.ifun), 64'(e.ifun));
        check("valid_instr", 64'(bus.valid_instr), 64'(e.valid));
        check("ins_mem_error", 64'(bus.ins_mem_error), 64'(e.memerr));
        check("halt", 64'(bus.halt), 64'(e.halt));
        check("zf", 64'(bus.zf), 64'(e.zf));
        check("sf", 64'(bus.sf), 64'(e.sf));
        check("of", 64'(bus.of), 64'(e.of));
        if (e.full) begin
          check("rA", 64'(bus.rA), 64'(e.ra));
          check("rB", 64'(bus.rB), 64'(e.rb));
          check("valC", bus.valC, e.valc);
          check("valP", bus.valP, e.valp);
          check("valA", bus.valA, e.vala);
          check("valB", bus.valB, e.valb);
        end
        if (e.full && e.valid) check("valE", bus.valE, e.vale);
        if (e.check_cnd) check("cnd", 64'(bus.cnd), 64'(e.cnd));
      end
    end
  end

  localparam logic [79:0] RD_RSP = {8'h40, 8'h4F, 64'd0};  // rmmovq %rsp,0(F): reads rsp only
  localparam logic [79:0] RD_RBX = {8'h40, 8'h3F, 64'd0};

  // Driver: directed plan followed by randomized traffic
  initial begin
    logic [63:0] pc;
    model_reset();
    rst = 1'b1;
    bus.PC = 64'd0; bus.instr = {8'h90, 72'd0}; bus.valM = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_zf", 64'(bus.zf), 64'd1);
    check("reset_sf", 64'(bus.sf), 64'd0);
    check("reset_of", 64'(bus.of), 64'd0);
    check("reset_rsp", bus.valA, 64'd0);
    rst = 1'b0;

    // Test 1: subtract producing a negative result, then halt
    issue(64'd0, irm(4'h3, 4'hF, 4'h3, 64'd4), 64'd0); next_cycle();
    issue(64'd10, irm(4'h3, 4'hF, 4'h2, 64'h600), 64'd0); next_cycle();
    issue(64'd20, rr(4'h6, 4'h1, 4'h2, 4'h3), 64'd0);
    #2 check("t1_sub_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FA04); next_cycle();
    issue(64'd22, 80'd0, 64'h55);
    #2 check("t1_halt", 64'(bus.halt), 64'd1);
    check("t1_sf", 64'(bus.sf), 64'd1);
    check("t1_zf", 64'(bus.zf), 64'd0);
    next_cycle();
    issue(64'd23, RD_RBX, 64'd0);
    #2 check("t1_rbx", bus.valA, 64'hFFFF_FFFF_FFFF_FA04); next_cycle();

    // Test 2: cmovg taken, then not taken after a zero result
    issue(64'd0, irm(4'h3, 4'hF, 4'h3, 64'd8), 64'd0); next_cycle();
    issue(64'd10, irm(4'h3, 4'hF, 4'h2, 64'd1), 64'd0); next_cycle();
    issue(64'd20, rr(4'h6, 4'h0, 4'h2, 4'h3), 64'd0); next_cycle();
    issue(64'd22, rr(4'h2, 4'h6, 4'h3, 4'h4), 64'd0);
    #2 check("t2_cnd_taken", 64'(bus.cnd), 64'd1); next_cycle();
    issue(64'd24, RD_RSP, 64'd0);
    #2 check("t2_rsp9", bus.valA, 64'd9); next_cycle();
    issue(64'd34, rr(4'h6, 4'h1, 4'h3, 4'h3), 64'd0); next_cycle();
    issue(64'd36, rr(4'h2, 4'h6, 4'h2, 4'h4), 64'd0);
    #2 check("t2_cnd_not", 64'(bus.cnd), 64'd0); next_cycle();
    issue(64'd38, RD_RSP, 64'd0);
    #2 check("t2_rsp_kept", bus.valA, 64'd9); next_cycle();

    // Test 3: illegal encodings and the memory bound
    issue(64'd0, {8'h0C, 72'd0}, 64'd0);
    #2 check("t3_icode_C", 64'(bus.valid_instr), 64'd0); next_cycle();
    issue(64'd2, rr(4'h6, 4'h4, 4'h2, 4'h3), 64'd0);
    #2 check("t3_opq_fn4", 64'(bus.valid_instr), 64'd0); next_cycle();
    issue(64'(IMEM - 5), irm(4'h3, 4'hF, 4'h3, 64'hDEAD), 64'd0);
    #2 check("t3_memerr", 64'(bus.ins_mem_error), 64'd1); next_cycle();
    issue(64'(IMEM - 10), RD_RBX, 64'd0);
    #2 check("t3_edge_ok", 64'(bus.ins_mem_error), 64'd0);
    check("t3_rbx_kept", bus.valA, 64'd0); next_cycle();

    // Test 4: call / ret
    issue(64'd0, irm(4'h3, 4'hF, 4'h4, 64'h100), 64'd0); next_cycle();
    issue(64'd21, {8'h80, 64'd1, 8'h00}, 64'd0);
    #2 check("t4_call_valE", bus.valE, 64'hF8);
    check("t4_call_valP", bus.valP, 64'd30); next_cycle();
    issue(64'd1, {8'h90, 72'd0}, 64'd30); next_cycle();
    issue(64'd30, RD_RSP, 64'd0);
    #2 check("t4_rsp_back", bus.valA, 64'h100); next_cycle();

    // Test 5: popq %rsp gives valM priority, then reset mid-cycle
    issue(64'd0, irm(4'h3, 4'hF, 4'h4, 64'h40), 64'd0); next_cycle();
    issue(64'd10, {8'hB0, 8'h4F, 64'd0}, 64'h77); next_cycle();
    issue(64'd12, RD_RSP, 64'd0);
    #2 check("t5_popq_rsp", bus.valA, 64'h77); next_cycle();
    issue(64'd0, irm(4'h3, 4'hF, 4'h3, 64'd5), 64'd0); next_cycle();
    issue(64'd10, rr(4'h6, 4'h0, 4'h3, 4'h3), 64'd0); next_cycle();
    issue(64'd12, {8'h90, 72'd0}, 64'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("t5_rst_zf", 64'(bus.zf), 64'd1);
    check("t5_rst_rsp", bus.valA, 64'd0);
    bus.instr = RD_RBX;
    #1 check("t5_rst_rbx", bus.valA, 64'd0);
    model_reset();
    next_cycle();
    rst = 1'b0;

    // Randomized phase: seed every register, then mixed traffic
    for (int r = 0; r < 15; r++) begin
      issue(64'(r * 10), irm(4'h3, 4'hF, 4'(r), {$urandom(), $urandom()}), 64'd0);
      next_cycle();
    end
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 3) == 0) ? 64'(IMEM - int'($urandom_range(1, 12)))
                                       : 64'($urandom_range(0, 4096));
      issue(pc, rand_instr(), {$urandom(), $urandom()});
      next_cycle();
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_decode_execute.md
Name: fetch_decode_execute

Overview:
Combined fetch, decode/writeback and execute stage of the single-cycle (SEQ) Y86-64 processor. Each cycle it:
- parses the 10-byte instruction window at PC;
- reads the 15-entry register file;
- computes valE, cnd and the condition codes.

On each rising clock edge it commits register writeback and the CC update. Data memory and next-PC selection are external; valM is returned from data memory.

Parameters:
IMEM_BYTES, 20480, instruction-memory size in bytes; an instruction whose bytes extend past it raises ins_mem_error.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
PC  in  64  address of the current instruction
instr  in  80  bytes PC..PC+9; byte at PC is instr[79:72]
valM  in  64  data-memory read result, used for writeback
icode, ifun, rA, rB  out  4 each  decoded fields (rA=rB=4'hF when absent)
valC  out  64  constant; multi-byte constants are MSB-first (lowest address = most significant byte)
valP  out  64  PC + instruction length
valA, valB  out  64  register operands
valE  out  64  ALU result
cnd  out  1  condition result for jXX/cmovXX (1 for unconditional)
zf, sf, of  out  1 each  current CC register
valid_instr, ins_mem_error, halt  out  1 each  status flags

Behaviour:
- Reset (asynchronous): all 15 registers = 0; ZF=1, SF=0, OF=0. No writeback in a cycle where rst is high.

Fetch:
- Lengths: halt, nop, ret = 1; cmov, OPq, pushq, popq = 2; jXX, call = 9; irmovq, rmmovq, mrmovq = 10.
- valC source: bytes 1..8 for jXX/call; bytes 2..9 for irmovq/rmmovq/mrmovq; 0 otherwise.
- valid_instr=0 when any of:
  - icode > 4'hB;
  - OPq with ifun > 3;
  - jXX/cmov with ifun > 6;
  - any other instruction with ifun != 0.
- halt = (icode == 0).
- ins_mem_error = (PC + length > IMEM_BYTES).

Decode (combinational; register ID F reads 0):
- srcA = rA for cmov, rmmovq, OPq, pushq; RSP(4) for ret, popq.
- srcB = rB for rmmovq, mrmovq, OPq; RSP for call, ret, pushq, popq.

Execute:
- valE by instruction:
  - cmov: valA.
  - irmovq: valC.
  - rmmovq, mrmovq: valB + valC.
  - OPq: valB op valA, where ifun 0=add, 1=sub (valB - valA), 2=and, 3=xor.
  - call, pushq: valB - 8.
  - ret, popq: valB + 8.
  - otherwise: 0.
- Arithmetic is 64-bit, wrap-around.
- New CC from the OPq result:
  - ZF = (result == 0); SF = result[63].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: sign(valB) != sign(valA) and sign(result) != sign(valB).
  - OF = 0 for and/xor.
- CC register loads at the rising edge only for a valid OPq.
- cnd uses the current CC register. ifun mapping:
  - 0 = always
  - 1 = le: (SF^OF)|ZF
  - 2 = l: SF^OF
  - 3 = e: ZF
  - 4 = ne: !ZF
  - 5 = ge: !(SF^OF)
  - 6 = g: !(SF^OF) & !ZF

Writeback (rising edge):
- dstE = rB for irmovq, OPq, and cmov when cnd=1; RSP for call, ret, pushq, popq.
- dstM = rA for mrmovq, popq.
- Writes to ID F are ignored.
- dstE == dstM: the M write wins (popq %rsp leaves rsp = valM).
- Writeback and CC update are suppressed when valid_instr=0, ins_mem_error=1 or halt=1.

Optional Feature:
- Macro: FDE_DBG_PORT_EN.
- When defined, add ports dbg_sel (in, 4) and dbg_data (out, 64): combinational register read, returning 0 for ID F.
- When undefined, these ports do not exist; core behaviour is identical.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ);
  - ALU function codes;
  - condition function codes;
  - RSP = 4'h4, RNONE = 4'hF.
- One sub-module, y86_regfile: 15x64 array, two async read ports, two write ports, async reset.

Test Plan:
1. irmovq $4,%rbx (30 F3 00..00 04); irmovq $0x600,%rdx; subq %rdx,%rbx (61 23) -> rbx = 0xFFFF_FFFF_FFFF_FA04; SF=1, ZF=0, OF=0; then halt (00) -> halt=1, no writeback.
2. irmovq $8,%rbx; irmovq $1,%rdx; addq; then cmovg %rbx,%rsp (26 34) -> cnd=1 and rsp=9. Repeat after a subq giving zero -> cnd=0, rsp unchanged.
3. Boundary cases:
   - Byte 0x0C at PC=0 -> valid_instr=0.
   - OPq with ifun 4 -> valid_instr=0.
   - irmovq at PC=IMEM_BYTES-5 -> ins_mem_error=1, registers unchanged.
4. call at PC=21 with valC=1, rsp=0x100 -> valE=0xF8, valP=30, rsp=0xF8 after the edge. ret with valM=30 -> rsp=0x100.
5. popq %rsp with rsp=0x40 and valM=0x77 -> rsp=0x77 (M priority). Assert rst mid-cycle -> all registers 0 and ZF=1 immediately.
